// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution window engine.
package conv_pkg;

  localparam int unsigned ACC_W  = 21;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned TAPS   = 9;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StConv,
    StAdv,
    StDrain
  } state_e;

  // Bit offset of tap (r,c) inside the packed 3x3 kernel.
  function automatic int tap_idx(input int r, input int c);
    return (r * 3 + c) * 8;
  endfunction

  // Bit offset of pixel (r,c) inside a packed row window of the given width.
  function automatic int pix_idx(input int r, input int c, input int width);
    return (r * width + c) * 8;
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) return 8'd0;
    if (|v[ACC_W-2:8]) return 8'hff;
    return v[7:0];
  endfunction

endpackage

// File: rtl/conv_window_engine_if.sv
// Handshake between the convolution engine and the row loader.
interface conv_window_engine_if #(
  parameter int unsigned IMAGE_WIDTH = 128,
  parameter int unsigned FILTER_SIZE = 3
);

  logic                                 load_en;
  logic                                 new_buffer;
  logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0] row_buffer_flat;
  logic                                 loaded;

  modport master (
    output load_en,
    output new_buffer,
    input  row_buffer_flat,
    input  loaded
  );

  modport slave (
    input  load_en,
    input  new_buffer,
    output row_buffer_flat,
    output loaded
  );

endinterface

// File: rtl/conv_mac9.sv
// Nine-tap multiply-accumulate: registered products, registered sum, valid/row/col sideband.
module conv_mac9 import conv_pkg::*; #(
  parameter int unsigned ROW_W = 7,
  parameter int unsigned COL_W = 7,
  parameter int unsigned SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ROW_W-1:0]        in_row,
  input  logic [COL_W-1:0]        in_col,
  input  logic [TAPS*8-1:0]       window,
  input  logic [TAPS*8-1:0]       taps,
  output logic                    out_valid,
  output logic [ROW_W-1:0]        out_row,
  output logic [COL_W-1:0]        out_col,
  output logic signed [ACC_W-1:0] acc,
  output logic [7:0]              pixel,
  output logic                    busy
);

  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [ACC_W-1:0]  sum_d;
  logic                     valid1_q;
  logic [ROW_W-1:0]         row1_q;
  logic [COL_W-1:0]         col1_q;

  // Pixels are unsigned, so zero-extend before the signed multiply.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, window[i*8 +: 8]})) * PROD_W'($signed(taps[i*8 +: 8]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_d = sum_d + ACC_W'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1_q  <= 1'b0;
      row1_q    <= '0;
      col1_q    <= '0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      acc       <= '0;
    end else begin
      valid1_q  <= in_valid;
      row1_q    <= in_row;
      col1_q    <= in_col;
      prod_q    <= prod_d;
      out_valid <= valid1_q;
      out_row   <= row1_q;
      out_col   <= col1_q;
      acc       <= sum_d;
    end
  end

  assign pixel = sat_u8(acc >>> SHIFT);
  assign busy  = valid1_q | out_valid;

endmodule

// File: rtl/conv_window_engine.sv
// Sequences the row loader and slides a 3x3 kernel across each loaded window band.
module conv_window_engine import conv_pkg::*; #(
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 128,
  parameter int unsigned FILTER_SIZE  = 3,
  parameter int unsigned SHIFT        = 0,
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT),
  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TAPS*8-1:0]       kernel_flat,
  conv_window_engine_if.master    ldr,
  output logic [7:0]              pixel_out,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    pixel_valid,
  output logic [ROW_W-1:0]        out_row,
  output logic [COL_W-1:0]        out_col,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OUT_W = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int unsigned OUT_H = IMAGE_HEIGHT - FILTER_SIZE + 1;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [TAPS*8-1:0]   kernel_q, kernel_d;
  logic                issue;
  logic                pipe_busy;
  logic [TAPS*8-1:0]   window;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      kernel_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      kernel_q <= kernel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    kernel_d = kernel_q;
    issue    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          kernel_d = kernel_flat;
          row_d    = '0;
          state_d  = StReq;
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (ldr.loaded) begin
          col_d   = '0;
          state_d = StConv;
        end else begin
          state_d = StReq;
        end
      end
      StConv: begin
        issue = 1'b1;
        // Column counter parks on the last column so the window mux never reads past the band.
        if (col_q == COL_W'(OUT_W - 1)) state_d = StAdv;
        else col_d = col_q + COL_W'(1);
      end
      StAdv: begin
        // Any loaded ack to this new_buffer pulse is stale; REQ ignores it.
        if (row_q == ROW_W'(OUT_H - 1)) begin
          state_d = StDrain;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = StReq;
        end
      end
      StDrain: begin
        if (!pipe_busy) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ldr.load_en    = (state_q == StReq);
  assign ldr.new_buffer = (state_q == StAdv);
  assign busy           = (state_q != StIdle);

  always_comb begin
    window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window[tap_idx(r, c) +: 8] =
          ldr.row_buffer_flat[pix_idx(r, int'(col_q) + c, int'(IMAGE_WIDTH)) +: 8];
      end
    end
  end

  conv_mac9 #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .SHIFT (SHIFT)
  ) u_mac9 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_row    (row_q),
    .in_col    (col_q),
    .window    (window),
    .taps      (kernel_q),
    .out_valid (pixel_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .acc       (acc_out),
    .pixel     (pixel_out),
    .busy      (pipe_busy)
  );

endmodule

// File: doc/conv_window_engine.md
Name: conv_window_engine

Overview:
- Consumes the FILTER_SIZE-row window produced by the row loader and slides an FILTER_SIZE x FILTER_SIZE kernel across it.
- Issues one output pixel per clock, then advances the loader to the next row band.
- Sits directly downstream of the loader. It drives the loader's load_en and new_buffer and reads its row_buffer_flat and loaded outputs.
- Output is a valid-qualified pixel stream, with coordinates, for the result writer.

Parameters:
- IMAGE_WIDTH, 128, pixels per row.
- IMAGE_HEIGHT, 128, rows per image.
- FILTER_SIZE, 3, kernel edge; fixed at 3 in this revision.
- SHIFT, 0, right arithmetic shift applied to the accumulator before 8-bit saturation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins one full-image pass.
- kernel_flat  in  72  nine signed 8-bit taps; tap (r,c) at bits [(r*3+c)*8 +: 8].
- row_buffer_flat  in  FILTER_SIZE*IMAGE_WIDTH*8  loader window; pixel (r,c) at [(r*IMAGE_WIDTH+c)*8 +: 8], unsigned.
- loaded  in  1  loader acknowledge; window valid.
- load_en  out  1  request that the loader fill the window at its current row.
- new_buffer  out  1  pulse that advances the loader's row pointer.
- pixel_out  out  8  saturated result.
- acc_out  out  ACC_W  full signed accumulator; ACC_W = 21.
- pixel_valid  out  1  pixel_out, acc_out, out_row and out_col are valid.
- out_row  out  $clog2(IMAGE_HEIGHT)  output row index.
- out_col  out  $clog2(IMAGE_WIDTH)  output column index.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Reset (async, rst=0): all outputs 0, state IDLE, counters 0, pipeline valid bits cleared. Reset mid-pass aborts the pass with no done pulse.
- Dimensions: OUT_W = IMAGE_WIDTH-FILTER_SIZE+1 and OUT_H = IMAGE_HEIGHT-FILTER_SIZE+1.
- Counters: row_idx counts 0..OUT_H-1 and col_idx counts 0..OUT_W-1.
- IDLE: on start=1, latch kernel_flat into kernel_q, clear row_idx, go to REQ. busy rises next cycle.
- start while busy is ignored. kernel_flat changes mid-pass have no effect.
- REQ: assert load_en for exactly one cycle, then go to WAIT.
- WAIT: if loaded=1, clear col_idx and go to CONV. If loaded=0, return to REQ (retry).
- CONV: each cycle issue window column col_idx, increment col_idx. After issuing col_idx=OUT_W-1, go to ADV.
- CONV: load_en and new_buffer stay 0 while in CONV, so the window remains stable.
- ADV: pulse new_buffer for one cycle. The loaded response to this pulse is ignored, because it carries a stale window.
- ADV, not last row: increment row_idx and go to REQ.
- ADV, last row (row_idx=OUT_H-1): go to DRAIN. This pulse wraps the loader pointer back to 0.
- DRAIN: wait for the pipeline to empty, pulse done for one cycle, clear busy, go to IDLE.
- Datapath stage 1: nine products pixel(r,col+c) (unsigned 8, zero-extended) * tap(r,c) (signed 8), each registered at 17 bits signed.
- Datapath stage 2: signed sum of the nine products, registered as acc_out (21 bits, cannot overflow).
- pixel_out = clamp(acc_out >>> SHIFT, 0, 255).
- Latency: pixel_valid asserts exactly 2 cycles after the issue cycle. out_row and out_col are pipelined alongside the data.
- Per-row cost: 1 (REQ) + 1 (WAIT) + OUT_W (CONV) + 1 (ADV) cycles.
- Output order: strictly raster, exactly OUT_W*OUT_H valid pulses per pass, no backpressure.

Decomposition:
- Shared package conv_pkg:
  - state enum {IDLE, REQ, WAIT, CONV, ADV, DRAIN};
  - ACC_W constant (21);
  - saturate-to-u8 function;
  - tap-index and pixel-index helper functions.
- Sub-module conv_mac9: the nine multipliers and adder tree with the two register stages, valid, row and column sideband, and async reset.
- The top level holds the FSM, the counters, kernel latching and window column selection.

Test Plan:
- Identity kernel (center=1, others 0), 8x6 ramp image pixel(r,c)=r*8+c, SHIFT=0, real loader model -> 24 pixels; pixel (i,j) = (i+1)*8+(j+1); done once; out_col 0..5 and out_row 0..3 in raster order.
- All-ones kernel, image all 255, SHIFT=0 -> acc_out=2295 and pixel_out=255 on every pixel; SHIFT=4 -> acc 2295, pixel_out=143.
- All taps -1, image all 10 -> acc_out=-90, pixel_out=0; tap (0,0)=-128 with pixel 255 and others 0 -> acc_out=-32640.
- Handshake: load_en pulses exactly once per row and precedes a loaded-high WAIT; exactly OUT_H new_buffer pulses; loader row pointer is 0 after done; a stub that holds loaded=0 twice forces two REQ retries with no pixels issued.
- start re-pulsed mid-pass and kernel_flat changed mid-pass -> ignored, results match the original kernel; second start after done -> identical output stream.
- rst asserted during CONV of row 2 -> all outputs 0 immediately (async), no done; a following start gives a complete correct pass.
